// File: rtl/fetch_queue_unit.sv
// Instruction prefetch queue: issues sequential reads and buffers {pc, instr} for decode.
// Optional perf counters (fetch_cnt, flush_cnt) are enabled by defining FETCH_PERF_CNT_EN.
module fetch_queue_unit #(
    parameter int unsigned PC_W     = 32,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic               jump_signal,
    input  logic [PC_W-1:0]    jump_to,
    output logic               imem_rd_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [15:0]        flush_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {FETCH, HOLD, REDIRECT} state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q;
    logic [PC_W-1:0]     inflight_pc_q;
    logic                inflight_q;
    logic [CW-1:0]       count_q;
    logic [AW-1:0]       head_q, tail_q;
    logic [PC_W-1:0]     pc_mem    [DEPTH];
    logic [INSTR_W-1:0]  instr_mem [DEPTH];

    logic push, pop, room;

    // A read in flight during a jump belongs to the old stream and is dropped.
    assign push      = inflight_q & ~jump_signal;
    assign pop       = out_valid & out_ready;
    assign room      = (count_q + CW'(inflight_q)) < CW'(DEPTH);
    assign out_valid = (count_q != '0);
    assign out_pc    = pc_mem[head_q];
    assign out_instr = instr_mem[head_q];
    assign imem_addr = pc_q;

    // REDIRECT issues the target read while the queue is still empty, so the
    // bubble seen by decode is just that cycle plus the memory latency.
    assign imem_rd_en = rst & (state_q != HOLD) & room & ~load_en & ~jump_signal;

    always_comb begin
        // NOTE: default first so every path assigns state_d; otherwise a latch is inferred.
        state_d = state_q;
        if (jump_signal) begin
            state_d = load_en ? HOLD : REDIRECT;
        end else begin
            case (state_q)
                FETCH:    if (load_en) state_d = HOLD;
                HOLD:     if (!load_en) state_d = FETCH;
                REDIRECT: state_d = load_en ? HOLD : FETCH;
                default:  state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: non-blocking assignments for all registered state so every
            // flop samples pre-edge values regardless of statement order.
            state_q       <= FETCH;
            pc_q          <= PC_W'(RESET_PC);
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
        end else begin
            state_q <= state_d;
            if (jump_signal) begin
                pc_q       <= jump_to;
                inflight_q <= 1'b0;
                count_q    <= '0;
                head_q     <= '0;
                tail_q     <= '0;
            end else begin
                if (imem_rd_en) begin
                    pc_q          <= pc_q + 1'b1;
                    inflight_pc_q <= pc_q;
                end
                inflight_q <= imem_rd_en;
                if (push) tail_q <= tail_q + 1'b1;
                if (pop)  head_q <= head_q + 1'b1;
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    // NOTE: queue storage has no reset; entries are only read when count_q says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]    <= inflight_pc_q;
            instr_mem[tail_q] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic discard;
    assign discard = ((count_q - CW'(pop)) != '0) | inflight_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else if (state_q != HOLD) begin
            if (push)                  fetch_cnt <= fetch_cnt + 1'b1;
            if (jump_signal && discard) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: reset, streaming, backpressure, jump, hold, PC wrap, mid-run reset.
module tb_fetch_queue_unit;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic        jump_signal;
    logic [31:0] jump_to;
    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [31:0] out_pc;

    logic [7:0]  jump_to8;
    logic        imem_rd_en8;
    logic [7:0]  imem_addr8;
    logic [15:0] imem_rdata8;
    logic        out_valid8;
    logic [15:0] out_instr8;
    logic [7:0]  out_pc8;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, fetch_cnt8;
    logic [15:0] flush_cnt, flush_cnt8;
`endif

    int total;
    int bad;

    fetch_queue_unit u_dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .jump_signal (jump_signal),
        .jump_to     (jump_to),
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    fetch_queue_unit #(.PC_W(8), .RESET_PC(254)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .load_en     (1'b0),
        .jump_signal (1'b0),
        .jump_to     (jump_to8),
        .imem_rd_en  (imem_rd_en8),
        .imem_addr   (imem_addr8),
        .imem_rdata  (imem_rdata8),
        .out_valid   (out_valid8),
        .out_ready   (1'b1),
        .out_instr   (out_instr8),
        .out_pc      (out_pc8)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt8),
        .flush_cnt   (flush_cnt8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory returns addr + 0x100, one cycle after the read.
    always @(posedge clk) begin
        if (imem_rd_en)  imem_rdata  <= 16'(imem_addr + 32'h100);
        if (imem_rd_en8) imem_rdata8 <= 16'(imem_addr8) + 16'h100;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b0;
        load_en     = 1'b0;
        jump_signal = 1'b0;
        jump_to     = '0;
        jump_to8    = '0;
        out_ready   = 1'b1;

        // Reset state and streaming with out_ready=1; 8-bit instance wraps its PC.
        repeat (2) step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_rd_en", 32'(imem_rd_en), 32'd0);
        check("rst_addr", imem_addr, 32'h20);
        rst = 1'b1;
        #1;
        check("first_rd_en", 32'(imem_rd_en), 32'd1);
        check("first_addr", imem_addr, 32'h20);
        check("pc8_fe", 32'(imem_addr8), 32'hFE);
        step();
        check("s1_addr", imem_addr, 32'h21);
        check("s1_valid", 32'(out_valid), 32'd0);
        check("pc8_ff", 32'(imem_addr8), 32'hFF);
        step();
        check("s2_pc", out_pc, 32'h20);
        check("s2_instr", 32'(out_instr), 32'h120);
        check("pc8_00", 32'(imem_addr8), 32'h00);
        check("pc8_head", 32'(out_pc8), 32'hFE);
        check("pc8_instr", 32'(out_instr8), 32'h1FE);
        step();
        check("s3_pc", out_pc, 32'h21);
        check("s3_instr", 32'(out_instr), 32'h121);
        step();
        check("s4_pc", out_pc, 32'h22);
        check("s4_instr", 32'(out_instr), 32'h122);

        // Backpressure: queue fills to exactly DEPTH entries.
        out_ready = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        repeat (10) step();
        check("full_rd_en", 32'(imem_rd_en), 32'd0);
        check("full_addr", imem_addr, 32'h24);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_head", out_pc, 32'h20);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("drain_pc", out_pc, 32'h20 + 32'(i));
        end

        // Jump with 3 queued entries and one read in flight.
        out_ready = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        repeat (4) step();
        check("pre_jump_valid", 32'(out_valid), 32'd1);
        check("pre_jump_rd_en", 32'(imem_rd_en), 32'd0);
        jump_signal = 1'b1;
        jump_to     = 32'h50;
        out_ready   = 1'b1;
        #1;
        check("jump_cycle_rd_en", 32'(imem_rd_en), 32'd0);
        step();
        jump_signal = 1'b0;
        #1;
        check("post_jump_valid", 32'(out_valid), 32'd0);
        check("post_jump_addr", imem_addr, 32'h50);
        check("post_jump_rd_en", 32'(imem_rd_en), 32'd1);
        step();
        check("bubble_valid", 32'(out_valid), 32'd0);
        step();
        check("target_valid", 32'(out_valid), 32'd1);
        check("target_pc", out_pc, 32'h50);
        check("target_instr", 32'(out_instr), 32'h150);
`ifdef FETCH_PERF_CNT_EN
        check("flush_cnt", 32'(flush_cnt), 32'd1);
`endif

        // Load hold: queued entries drain, PC frozen, no reads.
        out_ready = 1'b0;
        step();
        check("hold_pre_head", out_pc, 32'h50);
        load_en   = 1'b1;
        out_ready = 1'b1;
        #1;
        check("hold_enter_rd_en", 32'(imem_rd_en), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check("hold_rd_en", 32'(imem_rd_en), 32'd0);
            check("hold_addr", imem_addr, 32'h53);
            if (i == 1) check("hold_head1", out_pc, 32'h51);
            if (i == 2) check("hold_head2", out_pc, 32'h52);
            if (i >= 3) check("hold_empty", 32'(out_valid), 32'd0);
        end
        load_en = 1'b0;
        #1;
        check("hold_exit_rd_en", 32'(imem_rd_en), 32'd0);
        step();
        check("resume_rd_en", 32'(imem_rd_en), 32'd1);
        check("resume_addr", imem_addr, 32'h53);

        // Asynchronous reset pulse between edges with 3 queued entries.
        out_ready = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        repeat (4) step();
        check("pulse_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("pulse_valid", 32'(out_valid), 32'd0);
        check("pulse_rd_en", 32'(imem_rd_en), 32'd0);
        check("pulse_addr", imem_addr, 32'h20);
`ifdef FETCH_PERF_CNT_EN
        check("pulse_fetch_cnt", fetch_cnt, 32'd0);
`endif
        rst = 1'b1;
        #1;
        check("release_rd_en", 32'(imem_rd_en), 32'd1);
        check("release_addr", imem_addr, 32'h20);
        step();
        check("release_no_push", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
